// File: rtl/confreg_responder.sv
// Memory-mapped peripheral responder on the CPU data-SRAM port: LEDs, 7-seg value,
// switches, scratch register, free-running timer with compare interrupt and sim flags.
module confreg_responder #(
  parameter logic [15:0] BASE_HI    = 16'h1faf,
  parameter bit          SIMULATION = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch,
  output logic [15:0] led,
  output logic [1:0]  led_rg0,
  output logic [1:0]  led_rg1,
  output logic [31:0] num_data,
  output logic        timer_int
);

  localparam logic [15:0] OFF_CR0    = 16'h0000;
  localparam logic [15:0] OFF_LED    = 16'hf000;
  localparam logic [15:0] OFF_RG0    = 16'hf004;
  localparam logic [15:0] OFF_RG1    = 16'hf008;
  localparam logic [15:0] OFF_NUM    = 16'hf010;
  localparam logic [15:0] OFF_SWITCH = 16'hf020;
  localparam logic [15:0] OFF_TIMER  = 16'hf100;
  localparam logic [15:0] OFF_CMP    = 16'hf104;
  localparam logic [15:0] OFF_STAT   = 16'hf108;
  localparam logic [15:0] OFF_SIMU   = 16'hffec;
  localparam logic [15:0] OFF_IO     = 16'hfff8;

  logic [31:0] cr0_q, cr0_d, num_q, num_d, timer_q, timer_d, cmp_q, cmp_d;
  logic [31:0] io_q, io_d, rdata_q, rdata_d, rd_val;
  logic [15:0] led_q, led_d, sw_meta_q, sw_sync_q, off;
  logic [1:0]  rg0_q, rg0_d, rg1_q, rg1_d;
  logic        ten_q, ten_d, pend_q, pend_d;
  logic        hit, wr, rd, pend_set, pend_clr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    return r;
  endfunction

  // A request is taken in every cycle data_sram_en is high; there is no stall, so a
  // read always returns its data on data_sram_rdata exactly one cycle later.
  always_comb begin
    hit      = (data_sram_addr[31:16] == BASE_HI);
    off      = data_sram_addr[15:0] & 16'hfffc;
    wr       = data_sram_en && (data_sram_wen != 4'b0000) && hit;
    rd       = data_sram_en && (data_sram_wen == 4'b0000);
    cr0_d    = cr0_q;
    led_d    = led_q;
    rg0_d    = rg0_q;
    rg1_d    = rg1_q;
    num_d    = num_q;
    cmp_d    = cmp_q;
    ten_d    = ten_q;
    io_d     = io_q;
    timer_d  = timer_q + 32'd1;
    pend_set = (timer_q == cmp_q) && ten_q;
    pend_clr = 1'b0;
    if (wr) begin
      case (off)
        OFF_CR0: cr0_d = merge_bytes(cr0_q, data_sram_wdata, data_sram_wen);
        OFF_LED: begin
          if (data_sram_wen[0]) led_d[7:0]  = data_sram_wdata[7:0];
          if (data_sram_wen[1]) led_d[15:8] = data_sram_wdata[15:8];
        end
        OFF_RG0:   if (data_sram_wen[0]) rg0_d = data_sram_wdata[1:0];
        OFF_RG1:   if (data_sram_wen[0]) rg1_d = data_sram_wdata[1:0];
        OFF_NUM:   num_d = merge_bytes(num_q, data_sram_wdata, data_sram_wen);
        OFF_TIMER: timer_d = merge_bytes(timer_q, data_sram_wdata, data_sram_wen);
        OFF_CMP:   cmp_d = merge_bytes(cmp_q, data_sram_wdata, data_sram_wen);
        OFF_STAT: begin
          if (data_sram_wen[0]) begin
            ten_d    = data_sram_wdata[0];
            pend_clr = data_sram_wdata[1];
          end
        end
        OFF_IO: io_d = merge_bytes(io_q, {data_sram_wdata[15:0], data_sram_wdata[31:16]},
                                   data_sram_wen);
        default: ;
      endcase
    end
    // A compare hit in the same cycle as a clear keeps the interrupt pending.
    pend_d = pend_set | (pend_q & ~pend_clr);

    case (off)
      OFF_CR0:    rd_val = cr0_q;
      OFF_LED:    rd_val = {16'h0, led_q};
      OFF_RG0:    rd_val = {30'h0, rg0_q};
      OFF_RG1:    rd_val = {30'h0, rg1_q};
      OFF_NUM:    rd_val = num_q;
      OFF_SWITCH: rd_val = {16'h0, sw_sync_q};
      OFF_TIMER:  rd_val = timer_q;
      OFF_CMP:    rd_val = cmp_q;
      OFF_STAT:   rd_val = {30'h0, pend_q, ten_q};
      OFF_SIMU:   rd_val = {32{SIMULATION}};
      OFF_IO:     rd_val = io_q;
      default:    rd_val = 32'h0;
    endcase
    rdata_d = rdata_q;
    if (rd) rdata_d = hit ? rd_val : 32'h0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cr0_q     <= 32'h0;
      led_q     <= 16'hffff;
      rg0_q     <= 2'b00;
      rg1_q     <= 2'b00;
      num_q     <= 32'h0;
      timer_q   <= 32'h0;
      cmp_q     <= 32'hffffffff;
      ten_q     <= 1'b0;
      pend_q    <= 1'b0;
      io_q      <= 32'h0;
      rdata_q   <= 32'h0;
      sw_meta_q <= 16'h0;
      sw_sync_q <= 16'h0;
    end else begin
      cr0_q     <= cr0_d;
      led_q     <= led_d;
      rg0_q     <= rg0_d;
      rg1_q     <= rg1_d;
      num_q     <= num_d;
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
      ten_q     <= ten_d;
      pend_q    <= pend_d;
      io_q      <= io_d;
      rdata_q   <= rdata_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign led_rg0         = rg0_q;
  assign led_rg1         = rg1_q;
  assign num_data        = num_q;
  assign timer_int       = pend_q & ten_q;

endmodule

// File: tb/tb_confreg_responder.sv
// Bench for confreg_responder: directed register-map scenarios followed by random
// traffic, with read data checked through an expected queue against a reference model.
module tb_confreg_responder;

  localparam logic [15:0] BASE = 16'h1faf;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [15:0] switch, led;
  logic [1:0]  led_rg0, led_rg1;
  logic [31:0] num_data;
  logic        timer_int;

  confreg_responder #(.BASE_HI(BASE), .SIMULATION(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .switch(switch), .led(led),
    .led_rg0(led_rg0), .led_rg1(led_rg1), .num_data(num_data), .timer_int(timer_int)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic        rd_issued;
  logic [31:0] mon_exp;
  logic [15:0] cur_sw;

  // reference model state
  logic [31:0] m_cr0, m_num, m_timer, m_cmp, m_io;
  logic [15:0] m_led, m_meta, m_sync;
  logic [1:0]  m_rg0, m_rg1;
  logic        m_ten, m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = be[i] ? n[i*8 +: 8] : o[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    logic [15:0] o;
    o = {a[15:2], 2'b00};
    if (a[31:16] != BASE) return 32'h0;
    case (o)
      16'h0000: return m_cr0;
      16'hf000: return {16'h0, m_led};
      16'hf004: return {30'h0, m_rg0};
      16'hf008: return {30'h0, m_rg1};
      16'hf010: return m_num;
      16'hf020: return {16'h0, m_sync};
      16'hf100: return m_timer;
      16'hf104: return m_cmp;
      16'hf108: return {30'h0, m_pend, m_ten};
      16'hffec: return 32'hffffffff;
      16'hfff8: return m_io;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_cr0 = 0; m_led = 16'hffff; m_rg0 = 0; m_rg1 = 0; m_num = 0; m_timer = 0;
    m_cmp = 32'hffffffff; m_ten = 0; m_pend = 0; m_io = 0; m_meta = 0; m_sync = 0;
  endtask

  // Advance the model across one clock edge given the inputs of the ending cycle.
  task automatic model_edge(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                            input logic [31:0] wdata);
    logic [31:0] t_next, tmp;
    logic        set, clr;
    set    = (m_timer == m_cmp) && m_ten;
    clr    = 1'b0;
    t_next = m_timer + 32'd1;
    if (en && wen != 4'b0 && addr[31:16] == BASE) begin
      case ({addr[15:2], 2'b00})
        16'h0000: m_cr0 = merge(m_cr0, wdata, wen);
        16'hf000: begin tmp = merge({16'h0, m_led}, wdata, wen); m_led = tmp[15:0]; end
        16'hf004: if (wen[0]) m_rg0 = wdata[1:0];
        16'hf008: if (wen[0]) m_rg1 = wdata[1:0];
        16'hf010: m_num = merge(m_num, wdata, wen);
        16'hf100: t_next = merge(m_timer, wdata, wen);
        16'hf104: m_cmp = merge(m_cmp, wdata, wen);
        16'hf108: if (wen[0]) begin m_ten = wdata[0]; clr = wdata[1]; end
        16'hfff8: m_io = merge(m_io, {wdata[15:0], wdata[31:16]}, wen);
        default: ;
      endcase
    end
    m_timer = t_next;
    m_pend  = set | (m_pend & !clr);
    m_sync  = m_meta;
    m_meta  = cur_sw;
  endtask

  // ---------------- driver ----------------
  // One bus cycle: check direct outputs, drive request, predict, return 1 unit past the edge.
  task automatic step(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata);
    @(negedge clk);
    chk("led", {16'h0, led}, {16'h0, m_led});
    chk("led_rg0", {30'h0, led_rg0}, {30'h0, m_rg0});
    chk("led_rg1", {30'h0, led_rg1}, {30'h0, m_rg1});
    chk("num_data", num_data, m_num);
    chk("timer_int", {31'h0, timer_int}, {31'h0, m_pend & m_ten});
    data_sram_en = en; data_sram_wen = wen; data_sram_addr = addr; data_sram_wdata = wdata;
    switch = cur_sw;
    if (en && wen == 4'b0) exp_q.push_back(mdl_read(addr));
    model_edge(en, wen, addr, wdata);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] off, input logic [3:0] wen, input logic [31:0] d);
    step(1'b1, wen, {BASE, off}, d);
  endtask

  task automatic rd(input logic [31:0] addr);
    step(1'b1, 4'b0, addr, 32'h0);
  endtask

  task automatic idle();
    step(1'b0, 4'b0, 32'h0, 32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    exp_q.delete();
    model_reset();
    data_sram_en = 0; data_sram_wen = 0; data_sram_addr = 0; data_sram_wdata = 0;
    switch = cur_sw;
    resetn = 1'b1;
    model_edge(1'b0, 4'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk or negedge resetn) begin
    if (!resetn) rd_issued <= 1'b0;
    else         rd_issued <= data_sram_en && (data_sram_wen == 4'b0);
  end

  always @(negedge clk) begin
    if (resetn && rd_issued) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rdata_queue: read data %h with no expected entry", data_sram_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rdata", data_sram_rdata, mon_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [15:0] off_tab [0:13] = '{16'h0000, 16'hf000, 16'hf004, 16'hf008, 16'hf010, 16'hf020,
                                  16'hf100, 16'hf104, 16'hf108, 16'hffec, 16'hfff8, 16'h0004,
                                  16'hf00c, 16'h1234};

  initial begin
    logic [31:0] r, a, d;
    logic [15:0] hi, off;
    logic [3:0]  w;
    logic        en;
    resetn = 1'b0; cur_sw = 16'h0; switch = 16'h0;
    data_sram_en = 0; data_sram_wen = 0; data_sram_addr = 0; data_sram_wdata = 0;
    model_reset();
    repeat (3) @(negedge clk);
    release_reset();

    // reset state
    chk("reset_rdata", data_sram_rdata, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0000ffff);
    chk("reset_int", {31'h0, timer_int}, 32'h0);
    rd({BASE, 16'hf000});
    chk("t1_led_read", data_sram_rdata, 32'h0000ffff);

    // byte-enabled LED write
    wr(16'hf000, 4'b0001, 32'h12345678);
    chk("t2_led", {16'h0, led}, 32'h0000ff78);
    rd({BASE, 16'hf000});
    chk("t2_led_read", data_sram_rdata, 32'h0000ff78);

    // timer load and count
    wr(16'hf100, 4'hf, 32'h10);
    idle(); idle();
    rd({BASE, 16'hf100});
    chk("t3_timer", data_sram_rdata, 32'h12);

    // compare interrupt, clear, collision
    wr(16'hf104, 4'hf, 32'h20);
    wr(16'hf108, 4'b0001, 32'h1);
    wr(16'hf100, 4'hf, 32'h1e);
    idle(); idle();
    chk("t4_int_early", {31'h0, timer_int}, 32'h0);
    idle();
    chk("t4_int_set", {31'h0, timer_int}, 32'h1);
    wr(16'hf108, 4'b0001, 32'h3);
    chk("t4_int_clr", {31'h0, timer_int}, 32'h0);
    wr(16'hf100, 4'hf, 32'h1e);
    idle(); idle();
    wr(16'hf108, 4'b0001, 32'h3);
    chk("t4_collision", {31'h0, timer_int}, 32'h1);
    wr(16'hf108, 4'b0001, 32'h3);
    wr(16'hf108, 4'b0001, 32'h0);

    // IO_SIMU swap, misses, sim flag
    wr(16'hfff8, 4'hf, 32'haaaa5555);
    rd({BASE, 16'hfff8});
    chk("t5_io_swap", data_sram_rdata, 32'h5555aaaa);
    rd(32'h1faf0004);
    chk("t5_unmapped", data_sram_rdata, 32'h0);
    rd(32'h0000f000);
    chk("t5_miss", data_sram_rdata, 32'h0);
    rd({BASE, 16'hffec});
    chk("t5_simu_flag", data_sram_rdata, 32'hffffffff);

    // switch synchronizer latency
    cur_sw = 16'h00f0;
    idle(); idle();
    rd({BASE, 16'hf020});
    chk("t6_switch", data_sram_rdata, 32'h000000f0);

    // asynchronous reset in the middle of a write
    wr(16'hf010, 4'hf, 32'hdeadbeef);
    wr(16'hf004, 4'hf, 32'h3);
    @(negedge clk);
    data_sram_en = 1; data_sram_wen = 4'hf; data_sram_addr = {BASE, 16'hf000}; data_sram_wdata = 0;
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_led", {16'h0, led}, 32'h0000ffff);
    chk("t6_rst_num", num_data, 32'h0);
    chk("t6_rst_rg0", {30'h0, led_rg0}, 32'h0);
    chk("t6_rst_rdata", data_sram_rdata, 32'h0);
    chk("t6_rst_int", {31'h0, timer_int}, 32'h0);
    data_sram_en = 0; data_sram_wen = 0;
    @(negedge clk);
    release_reset();
    rd({BASE, 16'hf104});
    chk("t6_cmp_reset", data_sram_rdata, 32'hffffffff);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      r   = $urandom;
      hi  = ($urandom_range(0, 9) == 0) ? r[15:0] : BASE;
      off = off_tab[$urandom_range(0, 13)];
      a   = {hi, off[15:2], 2'($urandom_range(0, 3))};
      en  = ($urandom_range(0, 3) != 0);
      w   = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      d   = $urandom;
      if (off == 16'hf100 || off == 16'hf104) begin
        d = 32'($urandom_range(0, 40));
        if ($urandom_range(0, 1) == 0) w = 4'hf;
      end
      if ($urandom_range(0, 15) == 0) cur_sw = 16'($urandom);
      step(en, w, a, d);
    end

    idle(); idle();
    chk("drain", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
